// File: rtl/csr_if.sv
// CSR datapath bundle between the core pipeline (master) and csr_file (slave).
// Carries ID read port, WB write/retire/mret/wfi strobes, the external
// interrupt line and the fetch-redirect / stall controls back to the core.
interface csr_if;
   logic [11:0] rd_addr;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [31:0] wr_data;
   logic        instret_i;
   logic        mret_i;
   logic        wfi_i;
   logic [31:0] resume_pc;
   logic        ext_irq;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        wfi_stall;

   modport master (
      output rd_addr, input rd_data,
      output wr_en, output wr_addr, output wr_data,
      output instret_i, output mret_i, output wfi_i,
      output resume_pc, output ext_irq,
      input redirect, input redirect_pc, input wfi_stall
   );

   modport slave (
      input rd_addr, output rd_data,
      input wr_en, input wr_addr, input wr_data,
      input instret_i, input mret_i, input wfi_i,
      input resume_pc, input ext_irq,
      output redirect, output redirect_pc, output wfi_stall
   );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file and interrupt/trap sequencer for the RV32 core.
// Optional macro CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters;
// without it the counter addresses read 0 and ignore writes.
//
// state | meaning
// RUN   | normal execution, watching for irq / mret / wfi
// TRAP  | redirect fetch to mtvec for one cycle
// MRET  | redirect fetch to mepc for one cycle
// WFI   | pipeline frozen until a pending enabled interrupt arrives
module csr_file #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input logic clk,
   input logic rst_n,
   csr_if.slave bus
);

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] TRAP = 2'd1;
   localparam logic [1:0] MRET = 2'd2;
   localparam logic [1:0] WFI  = 2'd3;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTR   = 12'hB02;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_INSTR    = 12'hC02;
   localparam logic [11:0] A_INSTRH   = 12'hC82;

   logic [1:0]  state;
   logic        st_mie;
   logic        st_mpie;
   logic [1:0]  st_mpp;
   logic        mie_meie;
   logic [31:2] mtvec;
   logic [31:2] mepc;
   logic [31:2] mtvec_nxt;
   logic        irq_pend;
   logic        trap_take;
   logic        mret_take;
   logic        wfi_take;
   logic        wr_mstatus;
   logic        wr_mie;
   logic        wr_mtvec;
   logic        wr_mepc;
   logic [31:0] rd_val;
   logic        unused_sig;

   assign irq_pend   = bus.ext_irq & mie_meie;
   assign trap_take  = ((state == RUN) || (state == WFI)) && irq_pend && st_mie;
   assign mret_take  = (state == RUN) && !trap_take && bus.mret_i;
   assign wfi_take   = (state == RUN) && !trap_take && !bus.mret_i && bus.wfi_i;

   assign wr_mstatus = bus.wr_en && (bus.wr_addr == A_MSTATUS);
   assign wr_mie     = bus.wr_en && (bus.wr_addr == A_MIE);
   assign wr_mtvec   = bus.wr_en && (bus.wr_addr == A_MTVEC);
   assign wr_mepc    = bus.wr_en && (bus.wr_addr == A_MEPC);

   // A trap taken in the same cycle as an mtvec write vectors to the new base.
   assign mtvec_nxt  = wr_mtvec ? bus.wr_data[31:2] : mtvec;

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle;
   logic [63:0] minstret;

   // Cycle counter: a write to either half replaces it and skips the increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle <= 64'd0;
      end else if (bus.wr_en && (bus.wr_addr == A_MCYCLE)) begin
         mcycle[31:0] <= bus.wr_data;
      end else if (bus.wr_en && (bus.wr_addr == A_MCYCLEH)) begin
         mcycle[63:32] <= bus.wr_data;
      end else begin
         mcycle <= mcycle + 64'd1;
      end
   end

   // Retired-instruction counter, same write-over-increment rule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         minstret <= 64'd0;
      end else if (bus.wr_en && (bus.wr_addr == A_MINSTR)) begin
         minstret[31:0] <= bus.wr_data;
      end else if (bus.wr_en && (bus.wr_addr == A_MINSTRH)) begin
         minstret[63:32] <= bus.wr_data;
      end else if (bus.instret_i) begin
         minstret <= minstret + 64'd1;
      end
   end

   assign unused_sig = ^{bus.resume_pc[1:0]};
`else
   assign unused_sig = ^{bus.resume_pc[1:0], bus.wr_data[1:0], bus.instret_i};
`endif

   // mstatus: trap/mret updates take precedence over a software write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie  <= 1'b0;
         st_mpie <= 1'b0;
         st_mpp  <= 2'b00;
      end else if (trap_take) begin
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
         st_mpp  <= 2'b11;
      end else if (mret_take) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
         st_mpp  <= 2'b11;
      end else if (wr_mstatus) begin
         st_mie  <= bus.wr_data[3];
         st_mpie <= bus.wr_data[7];
         st_mpp  <= bus.wr_data[12:11];
      end
   end

   // mie, mtvec and mepc; mepc captures resume_pc on trap entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie_meie <= 1'b0;
         mtvec    <= MTVEC_RESET[31:2];
         mepc     <= 30'd0;
      end else begin
         if (wr_mie) begin
            mie_meie <= bus.wr_data[11];
         end
         mtvec <= mtvec_nxt;
         if (trap_take) begin
            mepc <= bus.resume_pc[31:2];
         end else if (wr_mepc && !mret_take) begin
            mepc <= bus.wr_data[31:2];
         end
      end
   end

   // Sequencer: redirect is a one-cycle registered pulse, wfi_stall tracks WFI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= RUN;
         bus.redirect    <= 1'b0;
         bus.redirect_pc <= 32'd0;
         bus.wfi_stall   <= 1'b0;
      end else begin
         bus.redirect <= 1'b0;
         case (state)
            RUN: begin
               if (trap_take) begin
                  state           <= TRAP;
                  bus.redirect    <= 1'b1;
                  bus.redirect_pc <= {mtvec_nxt, 2'b00};
               end else if (mret_take) begin
                  state           <= MRET;
                  bus.redirect    <= 1'b1;
                  bus.redirect_pc <= {mepc, 2'b00};
               end else if (wfi_take) begin
                  state         <= WFI;
                  bus.wfi_stall <= 1'b1;
               end
            end
            TRAP, MRET: begin
               state <= RUN;
            end
            WFI: begin
               if (trap_take) begin
                  state           <= TRAP;
                  bus.redirect    <= 1'b1;
                  bus.redirect_pc <= {mtvec_nxt, 2'b00};
                  bus.wfi_stall   <= 1'b0;
               end else if (irq_pend) begin
                  state         <= RUN;
                  bus.wfi_stall <= 1'b0;
               end
            end
            default: begin
               state         <= RUN;
               bus.wfi_stall <= 1'b0;
            end
         endcase
      end
   end

   // Combinational read mux; unimplemented addresses read 0.
   always_comb begin
      rd_val = 32'd0;
      case (bus.rd_addr)
         A_MSTATUS: rd_val = {19'd0, st_mpp, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
         A_MIE:     rd_val = {20'd0, mie_meie, 11'd0};
         A_MTVEC:   rd_val = {mtvec, 2'b00};
         A_MEPC:    rd_val = {mepc, 2'b00};
         A_MIP:     rd_val = {20'd0, bus.ext_irq, 11'd0};
`ifdef CSR_COUNTERS_EN
         A_MCYCLE,  A_CYCLE:  rd_val = mcycle[31:0];
         A_MCYCLEH, A_CYCLEH: rd_val = mcycle[63:32];
         A_MINSTR,  A_INSTR:  rd_val = minstret[31:0];
         A_MINSTRH, A_INSTRH: rd_val = minstret[63:32];
`endif
         default:   rd_val = 32'd0;
      endcase
   end

   assign bus.rd_data = rd_val;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: scoreboard queues hold expected read values and
// redirect targets, pushed when the stimulus is driven, popped on output.
module tb_csr_file;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   csr_if bus ();

   csr_file #(.MTVEC_RESET(32'h0000_0043)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rd(input logic [11:0] a, input logic [31:0] e, input string tag);
      bus.rd_addr = a;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #1;
      chk(tag_q.pop_front(), bus.rd_data, exp_q.pop_front());
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick;
      bus.wr_en   = 1'b0;
   endtask

   // Called one edge after the trigger was sampled; redirect should be up now.
   task automatic wait_redirect;
      int n = 1;
      string tag;
      while (!bus.redirect && n < 8) begin
         tick;
         n++;
      end
      tag = tag_q.pop_front();
      chk({tag, "_lat"}, bus.redirect ? n : 99, 1);
      chk({tag, "_pc"}, bus.redirect_pc, exp_q.pop_front());
      tick;
      chk({tag, "_pulse"}, bus.redirect, 0);
   endtask

   initial begin
      bus.rd_addr = 12'h000; bus.wr_en = 1'b0; bus.wr_addr = 12'h000;
      bus.wr_data = 32'd0;   bus.instret_i = 1'b0; bus.mret_i = 1'b0;
      bus.wfi_i = 1'b0;      bus.resume_pc = 32'd0; bus.ext_irq = 1'b0;

      repeat (3) tick;
      rst_n = 1'b1;
      tick;
      chk("rst_redirect", bus.redirect, 0);
      chk("rst_wfi_stall", bus.wfi_stall, 0);
      expect_rd(12'h305, 32'h0000_0040, "rst_mtvec");
      expect_rd(12'h300, 32'h0000_0000, "rst_mstatus");

      wr(12'h304, 32'hFFFF_FFFF);
      expect_rd(12'h304, 32'h0000_0800, "mie_mask");
      expect_rd(12'h344, 32'h0000_0000, "mip_low");
      bus.ext_irq = 1'b1;
      expect_rd(12'h344, 32'h0000_0800, "mip_high");
      tick;
      chk("no_trap_mie0", bus.redirect, 0);
      bus.ext_irq = 1'b0;

      wr(12'h300, 32'hFFFF_FFFF);
      expect_rd(12'h300, 32'h0000_1888, "mstatus_mask");
      expect_rd(12'h123, 32'h0000_0000, "unmapped");
      wr(12'h341, 32'h0000_1237);
      expect_rd(12'h341, 32'h0000_1234, "mepc_align");
      wr(12'h305, 32'h0000_0103);
      expect_rd(12'h305, 32'h0000_0100, "mtvec_align");
      wr(12'h344, 32'hFFFF_FFFF);
      expect_rd(12'h344, 32'h0000_0000, "mip_ro");

      // Interrupt entry with a colliding mstatus write that must be dropped.
      bus.resume_pc = 32'h0000_2004;
      bus.ext_irq = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 12'h300; bus.wr_data = 32'd0;
      exp_q.push_back(32'h0000_0100); tag_q.push_back("trap");
      tick;
      bus.ext_irq = 1'b0; bus.wr_en = 1'b0;
      wait_redirect;
      expect_rd(12'h341, 32'h0000_2004, "trap_mepc");
      expect_rd(12'h300, 32'h0000_1880, "trap_mstatus");

      bus.mret_i = 1'b1;
      exp_q.push_back(32'h0000_2004); tag_q.push_back("mret");
      tick;
      bus.mret_i = 1'b0;
      wait_redirect;
      expect_rd(12'h300, 32'h0000_1888, "mret_mstatus");

      // WFI with MIE clear: wake without trapping.
      wr(12'h300, 32'h0000_0000);
      bus.wfi_i = 1'b1;
      tick;
      bus.wfi_i = 1'b0;
      chk("wfi0_stall", bus.wfi_stall, 1);
      repeat (3) tick;
      chk("wfi0_hold", bus.wfi_stall, 1);
      bus.ext_irq = 1'b1;
      tick;
      chk("wfi0_wake", bus.wfi_stall, 0);
      chk("wfi0_noredir", bus.redirect, 0);
      tick;
      chk("wfi0_run", bus.redirect, 0);
      bus.ext_irq = 1'b0;

      // WFI with MIE set: wake into a trap.
      wr(12'h300, 32'h0000_0008);
      bus.wfi_i = 1'b1;
      tick;
      bus.wfi_i = 1'b0;
      chk("wfi1_stall", bus.wfi_stall, 1);
      bus.resume_pc = 32'h0000_3000;
      bus.ext_irq = 1'b1;
      exp_q.push_back(32'h0000_0100); tag_q.push_back("wfi_trap");
      tick;
      bus.ext_irq = 1'b0;
      chk("wfi1_wake", bus.wfi_stall, 0);
      wait_redirect;
      expect_rd(12'h341, 32'h0000_3000, "wfi_mepc");
      expect_rd(12'h300, 32'h0000_1880, "wfi_mstatus");

`ifdef CSR_COUNTERS_EN
      wr(12'hB00, 32'hFFFF_FFFF);
      tick;
      expect_rd(12'hB80, 32'h0000_0001, "mcycleh_carry");
      expect_rd(12'hB00, 32'h0000_0000, "mcycle_carry");
      expect_rd(12'hC80, 32'h0000_0001, "cycleh_shadow");
      wr(12'hB80, 32'hFFFF_FFFF);
      wr(12'hB00, 32'hFFFF_FFFF);
      tick;
      expect_rd(12'hB00, 32'h0000_0000, "mcycle_wrap_lo");
      expect_rd(12'hB80, 32'h0000_0000, "mcycle_wrap_hi");
      bus.instret_i = 1'b1;
      repeat (3) tick;
      bus.instret_i = 1'b0;
      expect_rd(12'hB02, 32'h0000_0003, "minstret");
      expect_rd(12'hC02, 32'h0000_0003, "instret_shadow");
      expect_rd(12'hB82, 32'h0000_0000, "minstreth");
`else
      wr(12'hB00, 32'hFFFF_FFFF);
      expect_rd(12'hB00, 32'h0000_0000, "nocnt_mcycle");
      expect_rd(12'hC00, 32'h0000_0000, "nocnt_cycle");
      bus.instret_i = 1'b1;
      repeat (3) tick;
      bus.instret_i = 1'b0;
      expect_rd(12'hB02, 32'h0000_0000, "nocnt_minstret");
`endif

      // Asynchronous reset while parked in WFI.
      bus.wfi_i = 1'b1;
      tick;
      bus.wfi_i = 1'b0;
      chk("rst_wfi_enter", bus.wfi_stall, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_stall", bus.wfi_stall, 0);
      chk("arst_redirect", bus.redirect, 0);
      expect_rd(12'h304, 32'h0000_0000, "arst_mie");
      expect_rd(12'h305, 32'h0000_0040, "arst_mtvec");
      tick;
      rst_n = 1'b1;
      repeat (2) tick;
      chk("post_rst_stall", bus.wfi_stall, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file and interrupt/trap sequencer for the 5-stage RV32 core.
- Responder side of the CSR datapath:
  - Supplies csr_rs to EX on reads addressed by ID.
  - Commits csr_result writes from WB.
- Owns mstatus/mie/mip/mtvec/mepc and the cycle/instret counters.
- Runs the interrupt-entry, MRET and WFI sequences, redirecting the fetch PC.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] forced to 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  12  CSR address from ID (instruction[31:20])
- rd_data  out  32  CSR read value to EX (csr_rs), combinational
- wr_en  in  1  CSR write commit from WB
- wr_addr  in  12  CSR address in WB
- wr_data  in  32  csr_result in WB
- instret_i  in  1  one instruction retired in WB this cycle
- mret_i  in  1  MRET in WB
- wfi_i  in  1  WFI in WB
- resume_pc  in  32  PC at which execution resumes after a trap (next unretired instruction)
- ext_irq  in  1  external interrupt, level-sensitive
- redirect  out  1  fetch redirect pulse, registered
- redirect_pc  out  32  redirect target, registered
- wfi_stall  out  1  freeze pipeline while waiting in WFI, registered

Behaviour:
Reset:
- mstatus = 0, mie = 0, mepc = 0, mtvec = MTIVEC_RESET, counters = 0.
- State = RUN; redirect = 0, redirect_pc = 0, wfi_stall = 0.

Implemented CSRs (unlisted addresses read 0, writes ignored):
- 0x300 mstatus: only MIE[3], MPIE[7], MPP[12:11] stored; other bits read 0.
- 0x304 mie: only MEIE[11] stored.
- 0x305 mtvec: bits [1:0] read 0 (direct mode).
- 0x341 mepc: bits [1:0] read 0.
- 0x344 mip: MEIP[11] = ext_irq; read-only.
- 0xB00/0xB80 mcycle/mcycleh; 0xB02/0xB82 minstret/minstreth: read/write.
- 0xC00/0xC80/0xC02/0xC82: read-only shadows of the counters.

Read/write timing:
- Read is pure combinational from current register state.
- A read in the same cycle as a write to the same CSR returns the old value; EX forwarding covers that hazard.

Counters:
- 64-bit; mcycle += 1 every cycle; minstret += 1 when instret_i.
- A write to either half in a cycle replaces that half; the increment is suppressed for the full 64-bit counter that cycle.
- Wrap from all-ones to 0 silently.

irq_pend = ext_irq & mie.MEIE.

FSM states: RUN, TRAP, MRET, WFI.
RUN:
- irq_pend & mstatus.MIE -> TRAP.
  - At the transition edge: mepc <= resume_pc, MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
- else mret_i -> MRET.
  - At the transition edge: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
- else wfi_i -> WFI.
- Priority: interrupt > mret > wfi.
TRAP:
- redirect = 1, redirect_pc = mtvec for exactly one cycle, then -> RUN.
MRET:
- redirect = 1, redirect_pc = mepc (value after any same-edge update) for one cycle, then -> RUN.
WFI:
- wfi_stall = 1.
- irq_pend & MIE -> TRAP (with the trap updates above).
- irq_pend & !MIE -> RUN (resume, no trap).
- Otherwise stay in WFI.

Simultaneous events:
- CSR write to mstatus or mepc in the trap/mret edge cycle is dropped; trap/mret updates win.
- Writes to other CSRs in that cycle commit normally.
- Interrupt entry is not taken while in TRAP or MRET; re-evaluated in RUN.

Reset mid-operation:
- Async reset in any state returns to RUN immediately.
- redirect and wfi_stall deassert asynchronously.

Latency: redirect appears the cycle after the triggering condition is sampled.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined: mcycle/minstret as specified.
- Undefined: no counter flops; all eight counter addresses read 0, writes ignored, instret_i unused.

Test Plan:
- Reset release -> rd_data at 0x305 = MTVEC_RESET, 0x300 = 0, redirect = 0, wfi_stall = 0.
- Write 0x300 <= 32'hFFFF_FFFF -> read 0x300 = 32'h0000_1888; write 0x304 <= 32'hFFFF_FFFF -> read 32'h0000_0800.
- Interrupt entry: MIE = 1, MEIE = 1, mtvec = 0x100, resume_pc = 0x2004, ext_irq = 1 -> next cycle redirect = 1, redirect_pc = 0x100; mepc = 0x2004; mstatus = 0x1880.
- MRET from that state -> redirect_pc = 0x2004; mstatus = 0x1888.
- WFI wakeup:
  - wfi_i with MIE = 0, MEIE = 1 -> wfi_stall held; ext_irq = 1 -> RUN, no redirect.
  - Repeat with MIE = 1 -> TRAP.
- Counters (CSR_COUNTERS_EN):
  - Write 0xB00 <= 32'hFFFF_FFFF; 1 cycle later 0xB80 reads 1, 0xB00 reads 0.
  - With 3 instret_i pulses, minstret = 3.
